// File: rtl/bitwise_pkg.sv
// Shared types and helpers for the calculator's bitwise logic unit.
// The operation helper works on single bits so any operand width can reuse it.
package bitwise_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_NOTA = 3'd2,
        OP_XOR  = 3'd3,
        OP_NAND = 3'd4,
        OP_NOR  = 3'd5,
        OP_XNOR = 3'd6,
        OP_NOTB = 3'd7
    } op_t;

    localparam op_t MODE_RESET = OP_AND;

    function automatic logic bitwise_op(op_t op, logic a, logic b);
        logic r;
        r = 1'b0;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_NOTA: r = ~a;
            OP_XOR:  r = a ^ b;
            OP_NAND: r = ~(a & b);
            OP_NOR:  r = ~(a | b);
            OP_XNOR: r = ~(a ^ b);
            OP_NOTB: r = ~b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bitwise_unit_button_debounce.sv
// Push-button conditioner: two-flop synchroniser, stability counter,
// and a single-cycle registered pulse on each accepted press.
module button_debounce
    import bitwise_pkg::*;
#(
    parameter int DEB_CYCLES = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic pressed
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          pressed_q, pressed_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // Count how long a new level has persisted; accept it once stable.
    always_comb begin
        level_d   = level_q;
        cnt_d     = '0;
        pressed_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d   = sync2_q;
                pressed_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Debounce state and the press pulse register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q   <= 1'b0;
            cnt_q     <= '0;
            pressed_q <= 1'b0;
        end else begin
            level_q   <= level_d;
            cnt_q     <= cnt_d;
            pressed_q <= pressed_d;
        end
    end

    assign pressed = pressed_q;

endmodule

// File: rtl/bitwise_unit.sv
// Bitwise logic unit: button-stepped mode register and a registered
// WIDTH-bit result of the selected operation on a and b.
module bitwise_unit
    import bitwise_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEB_CYCLES = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             btn_next,
    input  logic             btn_prev,
    input  logic             enable,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic [2:0]       mode
);

    logic             next_p, prev_p;
    op_t              mode_q, mode_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] op_res;

    button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_next (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_next),
        .pressed (next_p)
    );

    button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_prev (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_prev),
        .pressed (prev_p)
    );

    // Apply the selected operation bit by bit.
    always_comb begin
        op_res = '0;
        for (int i = 0; i < WIDTH; i++) begin
            op_res[i] = bitwise_op(mode_q, a[i], b[i]);
        end
    end

    // Step the mode; simultaneous presses cancel out.
    always_comb begin
        mode_d = mode_q;
        if (next_p && !prev_p) begin
            mode_d = op_t'(mode_q + 3'd1);
        end else if (prev_p && !next_p) begin
            mode_d = op_t'(mode_q - 3'd1);
        end
    end

    // Result only advances while enabled.
    always_comb begin
        result_d = result_q;
        valid_d  = valid_q;
        if (enable) begin
            result_d = op_res;
            valid_d  = 1'b1;
        end
    end

    // Architectural state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q   <= MODE_RESET;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    assign result       = result_q;
    assign result_valid = valid_q;
    assign mode         = mode_q;

endmodule

// File: tb/tb_bitwise_unit.sv
// Self-checking bench for bitwise_unit: two widths share buttons and
// enable, checked every cycle against a window-based behavioural model.
module tb_bitwise_unit;

    localparam int DEB = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  a8, b8;
    logic [15:0] a16, b16;
    logic        btn_next, btn_prev, enable;
    logic [7:0]  res8;
    logic [15:0] res16;
    logic        val8, val16;
    logic [2:0]  mode8, mode16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bitwise_unit #(.WIDTH(8), .DEB_CYCLES(DEB)) u8 (
        .clk          (clk),
        .reset        (reset),
        .a            (a8),
        .b            (b8),
        .btn_next     (btn_next),
        .btn_prev     (btn_prev),
        .enable       (enable),
        .result       (res8),
        .result_valid (val8),
        .mode         (mode8)
    );

    bitwise_unit #(.WIDTH(16), .DEB_CYCLES(DEB)) u16 (
        .clk          (clk),
        .reset        (reset),
        .a            (a16),
        .b            (b16),
        .btn_next     (btn_next),
        .btn_prev     (btn_prev),
        .enable       (enable),
        .result       (res16),
        .result_valid (val16),
        .mode         (mode16)
    );

    function automatic logic [15:0] ref_op(logic [2:0] m, logic [15:0] x, logic [15:0] y);
        logic [15:0] r;
        r = '0;
        case (m)
            3'd0: r = x & y;
            3'd1: r = x | y;
            3'd2: r = ~x;
            3'd3: r = x ^ y;
            3'd4: r = ~(x & y);
            3'd5: r = ~(x | y);
            3'd6: r = ~(x ^ y);
            3'd7: r = ~y;
        endcase
        return r;
    endfunction

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a level is accepted when the last DEB synchronised samples
    // (raw samples from 2..DEB+1 edges ago) all differ from the accepted one.
    logic [DEB:0] hn_q = '0, hp_q = '0;
    logic         acc_n = 1'b0, acc_p = 1'b0;
    logic         pn = 1'b0, pp = 1'b0;
    logic [2:0]   m_mode = '0;
    logic [7:0]   m_r8 = '0;
    logic [15:0]  m_r16 = '0;
    logic         m_valid = 1'b0;
    logic         fn, fp;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            hn_q    <= '0;
            hp_q    <= '0;
            acc_n   <= 1'b0;
            acc_p   <= 1'b0;
            pn      <= 1'b0;
            pp      <= 1'b0;
            m_mode  <= '0;
            m_r8    <= '0;
            m_r16   <= '0;
            m_valid <= 1'b0;
        end else begin
            fn = (hn_q[DEB:1] == {DEB{!acc_n}});
            fp = (hp_q[DEB:1] == {DEB{!acc_p}});
            if (enable) begin
                m_r8    <= ref_op(m_mode, {8'h00, a8}, {8'h00, b8}) & 16'h00FF;
                m_r16   <= ref_op(m_mode, a16, b16);
                m_valid <= 1'b1;
            end
            if (pn && !pp) m_mode <= m_mode + 3'd1;
            else if (pp && !pn) m_mode <= m_mode - 3'd1;
            hn_q  <= {hn_q[DEB-1:0], btn_next};
            hp_q  <= {hp_q[DEB-1:0], btn_prev};
            acc_n <= fn ? !acc_n : acc_n;
            acc_p <= fp ? !acc_p : acc_p;
            pn    <= fn && !acc_n;
            pp    <= fp && !acc_p;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        check("mode8", {13'b0, mode8}, {13'b0, m_mode});
        check("mode16", {13'b0, mode16}, {13'b0, m_mode});
        check("res8", {8'b0, res8}, {8'b0, m_r8});
        check("res16", res16, m_r16);
        check("valid8", {15'b0, val8}, {15'b0, m_valid});
        check("valid16", {15'b0, val16}, {15'b0, m_valid});
    end

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(logic nx, logic pv, int hold, int rel);
        btn_next = nx;
        btn_prev = pv;
        cyc(hold);
        btn_next = 1'b0;
        btn_prev = 1'b0;
        cyc(rel);
    endtask

    logic [7:0] tbl [8];
    int         hold;

    initial begin
        tbl[0] = 8'hFC; tbl[1] = 8'h0F; tbl[2] = 8'hCC; tbl[3] = 8'hCF;
        tbl[4] = 8'h03; tbl[5] = 8'h33; tbl[6] = 8'hC3; tbl[7] = 8'h30;
        reset = 1'b1;
        a8 = 8'hF0; b8 = 8'h3C;
        a16 = 16'hFF00; b16 = 16'h0FF0;
        btn_next = 1'b0; btn_prev = 1'b0;
        enable = 1'b1;
        cyc(2);
        check("rst_mode", {13'b0, mode8}, 16'h0);
        check("rst_res", {8'b0, res8}, 16'h0);
        check("rst_valid", {15'b0, val8}, 16'h0);
        reset = 1'b0;
        cyc(1);
        check("first_res", {8'b0, res8}, 16'h0030);
        check("first_valid", {15'b0, val8}, 16'h1);

        for (int i = 0; i < 8; i++) begin
            press(1'b1, 1'b0, 10, 10);
            check("step_mode", {13'b0, mode8}, 16'((i + 1) % 8));
            check("step_res", {8'b0, res8}, {8'b0, tbl[i]});
            if (i == 2) check("xor16", res16, 16'hF0F0);
        end

        press(1'b0, 1'b1, 10, 10);
        check("prev_mode", {13'b0, mode8}, 16'h7);
        check("prev_res", {8'b0, res8}, 16'h00C3);
        press(1'b1, 1'b1, 10, 10);
        check("both_mode", {13'b0, mode8}, 16'h7);
        press(1'b1, 1'b0, 10, 10);

        for (int g = 0; g < 4; g++) press(1'b1, 1'b0, 3, 3);
        cyc(10);
        check("glitch_mode", {13'b0, mode8}, 16'h0);
        press(1'b1, 1'b0, 50, 10);
        check("bounce_mode", {13'b0, mode8}, 16'h1);
        check("bounce_res", {8'b0, res8}, 16'h00FC);

        enable = 1'b0;
        a8 = 8'hAA; b8 = 8'h55;
        press(1'b1, 1'b0, 10, 10);
        check("hold_mode", {13'b0, mode8}, 16'h2);
        check("hold_res", {8'b0, res8}, 16'h00FC);
        enable = 1'b1;
        cyc(1);
        check("resume_res", {8'b0, res8}, 16'h0055);

        for (int k = 0; k < 300; k++) begin
            btn_next = 1'($urandom_range(0, 1));
            btn_prev = 1'($urandom_range(0, 2) == 0);
            hold = int'($urandom_range(1, 12));
            for (int c = 0; c < hold + 8; c++) begin
                if (c == hold) begin
                    btn_next = 1'b0;
                    btn_prev = 1'b0;
                end
                a8 = 8'($urandom);
                b8 = 8'($urandom);
                a16 = 16'($urandom);
                b16 = 16'($urandom);
                enable = ($urandom_range(0, 3) != 0);
                cyc(1);
            end
        end

        enable = 1'b1;
        a8 = 8'hF0; b8 = 8'h3C;
        a16 = 16'hFF00; b16 = 16'h0FF0;
        btn_next = 1'b0; btn_prev = 1'b0;
        cyc(10);
        btn_next = 1'b1;
        cyc(4);
        reset = 1'b1;
        cyc(1);
        check("mid_mode", {13'b0, mode8}, 16'h0);
        check("mid_res16", res16, 16'h0);
        check("mid_valid", {15'b0, val16}, 16'h0);
        cyc(1);
        reset = 1'b0;
        cyc(20);
        btn_next = 1'b0;
        cyc(10);
        check("post_mode", {13'b0, mode16}, 16'h1);
        check("post_res16", res16, 16'hFFF0);
        check("post_res8", {8'b0, res8}, 16'h00FC);

        cyc(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
